// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared PWM definitions: default widths and the duty sequencer state encoding.
package pwm_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int HOLD_W_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UP      = 3'd1;
  localparam logic [2:0] ST_HOLD_HI = 3'd2;
  localparam logic [2:0] ST_DOWN    = 3'd3;
  localparam logic [2:0] ST_HOLD_LO = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_UP      = ST_UP,
    S_HOLD_HI = ST_HOLD_HI,
    S_DOWN    = ST_DOWN,
    S_HOLD_LO = ST_HOLD_LO
  } seq_state_e;

endpackage

// File: rtl/pwm_duty_sequencer_hold_counter.sv
// Tick-driven hold down-counter: load, decrement on tick, clear, zero flag.
module hold_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Breathing-pattern duty sequencer driven by divider ticks.
// state   | meaning
// IDLE    | waiting for start, duty held at 0
// UP      | duty += step per tick, saturating at max
// HOLD_HI | dwell at max for hold+1 ticks
// DOWN    | duty -= step per tick, floor at 0
// HOLD_LO | dwell at 0 for hold+1 ticks, then end of breath
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              repeat_en,
  input  logic [DUTY_W-1:0] cfg_step,
  input  logic [DUTY_W-1:0] cfg_max,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              busy,
  output logic              cycle_done
);

  seq_state_e        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] step_q, step_d;
  logic [DUTY_W-1:0] max_q, max_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_q, rep_d;
  logic              duty_upd_q, duty_upd_d;
  logic              busy_q, busy_d;
  logic              cycle_done_q, cycle_done_d;

  logic              cnt_clr, cnt_load, cnt_dec, cnt_zero;
  logic [DUTY_W:0]   up_sum;

  // One extra bit so the ramp cannot wrap before saturation.
  assign up_sum = {1'b0, duty_q} + {1'b0, step_q};

  hold_counter #(.W(HOLD_W)) u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (hold_q),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    step_d       = step_q;
    max_d        = max_q;
    hold_d       = hold_q;
    rep_d        = rep_q;
    cycle_done_d = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    if ((state_q != S_IDLE) && stop) begin
      state_d = S_IDLE;
      duty_d  = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            step_d  = (cfg_step == '0) ? DUTY_W'(1) : cfg_step;
            max_d   = cfg_max;
            hold_d  = cfg_hold;
            rep_d   = repeat_en;
            duty_d  = '0;
            state_d = S_UP;
          end
        end
        S_UP: begin
          if (tick) begin
            if (up_sum >= {1'b0, max_q}) begin
              duty_d   = max_q;
              state_d  = S_HOLD_HI;
              cnt_load = 1'b1;
            end else begin
              duty_d = up_sum[DUTY_W-1:0];
            end
          end
        end
        S_HOLD_HI: begin
          if (tick) begin
            if (cnt_zero) state_d = S_DOWN;
            else          cnt_dec = 1'b1;
          end
        end
        S_DOWN: begin
          if (tick) begin
            if (duty_q > step_q) begin
              duty_d = duty_q - step_q;
            end else begin
              duty_d   = '0;
              state_d  = S_HOLD_LO;
              cnt_load = 1'b1;
            end
          end
        end
        S_HOLD_LO: begin
          if (tick) begin
            if (cnt_zero) begin
              cycle_done_d = 1'b1;
              state_d      = rep_q ? S_UP : S_IDLE;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = '0;
        end
      endcase
    end

    duty_upd_d = (duty_d != duty_q);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      duty_q       <= '0;
      step_q       <= '0;
      max_q        <= '0;
      hold_q       <= '0;
      rep_q        <= 1'b0;
      duty_upd_q   <= 1'b0;
      busy_q       <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      step_q       <= step_d;
      max_q        <= max_d;
      hold_q       <= hold_d;
      rep_q        <= rep_d;
      duty_upd_q   <= duty_upd_d;
      busy_q       <= busy_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign duty       = duty_q;
  assign duty_upd   = duty_upd_q;
  assign busy       = busy_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench: breath sequences are generated as per-tick duty lists and compared tick by tick.
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, start, stop, repeat_en;
  logic [7:0] cfg_step, cfg_max, cfg_hold;
  logic [7:0] duty;
  logic       duty_upd, busy, cycle_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int q_duty[$];
  bit q_done[$];
  int exp_prev  = 0;
  int upd_seen  = 0;
  int done_seen = 0;
  bit scramble  = 1'b0;

  pwm_duty_sequencer #(.DUTY_W(8), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .repeat_en  (repeat_en),
    .cfg_step   (cfg_step),
    .cfg_max    (cfg_max),
    .cfg_hold   (cfg_hold),
    .duty       (duty),
    .duty_upd   (duty_upd),
    .busy       (busy),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  // One clock with the given tick level; outputs are sampled 1 ns after the edge.
  task automatic cyc(input bit t);
    tick = t;
    if (scramble && !start) begin
      cfg_step  = 8'($urandom);
      cfg_max   = 8'($urandom);
      cfg_hold  = 8'($urandom);
      repeat_en = 1'($urandom);
    end
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    if (duty_upd)   upd_seen++;
    if (cycle_done) done_seen++;
  endtask

  task automatic do_start(input int s, input int m, input int h, input bit rep);
    cfg_step  = 8'(s);
    cfg_max   = 8'(m);
    cfg_hold  = 8'(h);
    repeat_en = rep;
    start     = 1'b1;
    cyc(1'b0);
    upd_seen  = 0;
    done_seen = 0;
  endtask

  // Expected duty after each tick of n breaths, derived from the ramp/hold rules.
  task automatic build(input int s, input int m, input int h, input int n);
    int se, d;
    se = (s == 0) ? 1 : s;
    for (int b = 0; b < n; b++) begin
      d = 0;
      do begin
        d = (d + se > m) ? m : d + se;
        q_duty.push_back(d); q_done.push_back(1'b0);
      end while (d != m);
      for (int i = 0; i <= h; i++) begin
        q_duty.push_back(m); q_done.push_back(1'b0);
      end
      do begin
        d = (d > se) ? d - se : 0;
        q_duty.push_back(d); q_done.push_back(1'b0);
      end while (d != 0);
      for (int i = 0; i <= h; i++) begin
        q_duty.push_back(0); q_done.push_back(i == h);
      end
    end
  endtask

  task automatic run_model(input int n, input bit ends_idle, input int maxgap);
    int k, gap, d;
    bit dn, eb;
    k = 0;
    while (q_duty.size() > 0 && (n < 0 || k < n)) begin
      gap = $urandom_range(0, maxgap);
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0);
        total_cnt++;
        if (duty !== 8'(exp_prev) || duty_upd !== 1'b0 || cycle_done !== 1'b0)
          $display("FAIL gap_quiet: duty=%0d upd=%0b done=%0b, required duty=%0d upd=0 done=0",
                   duty, duty_upd, cycle_done, exp_prev);
        else pass_cnt++;
      end
      d  = q_duty.pop_front();
      dn = q_done.pop_front();
      eb = !(ends_idle && dn && q_duty.size() == 0);
      cyc(1'b1);
      total_cnt++;
      if (duty !== 8'(d)) $display("FAIL tick_duty: got %0d, required %0d", duty, d);
      else pass_cnt++;
      total_cnt++;
      if (duty_upd !== (d != exp_prev)) $display("FAIL tick_upd: got %0b, required %0b", duty_upd, (d != exp_prev));
      else pass_cnt++;
      total_cnt++;
      if (cycle_done !== dn || busy !== eb)
        $display("FAIL tick_done_busy: done=%0b busy=%0b, required done=%0b busy=%0b", cycle_done, busy, dn, eb);
      else pass_cnt++;
      exp_prev = d;
      k++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tick = 0; start = 0; stop = 0; repeat_en = 0;
    cfg_step = 0; cfg_max = 0; cfg_hold = 0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (duty !== 8'd0 || duty_upd !== 1'b0 || busy !== 1'b0 || cycle_done !== 1'b0)
      $display("FAIL reset_outputs: duty=%0d upd=%0b busy=%0b done=%0b, required all 0", duty, duty_upd, busy, cycle_done);
    else pass_cnt++;
    rst = 1'b0;
    cyc(1'b0);
  endtask

  task automatic test_basic_ramp;
    int exp_seq[12] = '{64, 128, 192, 255, 255, 191, 127, 63, 0, 0, 0, 0};
    do_start(64, 255, 0, 0);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1);
      total_cnt++;
      if (duty !== 8'(exp_seq[k])) $display("FAIL basic_duty[%0d]: got %0d, required %0d", k, duty, exp_seq[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_seen !== 1 || busy !== 1'b0)
      $display("FAIL basic_end: done pulses=%0d busy=%0b, required 1 and 0", done_seen, busy);
    else pass_cnt++;
    exp_prev = 0;
  endtask

  task automatic test_hold_count;
    do_start(255, 200, 3, 0);
    build(255, 200, 3, 1);
    run_model(-1, 1'b1, 2);
    total_cnt++;
    if (upd_seen !== 2) $display("FAIL hold_upd_count: got %0d, required 2", upd_seen);
    else pass_cnt++;
  endtask

  task automatic test_repeat_stop;
    do_start(100, 250, 0, 1);
    build(100, 250, 0, 3);
    run_model(-1, 1'b0, 1);
    total_cnt++;
    if (done_seen !== 3) $display("FAIL repeat_done_count: got %0d, required 3", done_seen);
    else pass_cnt++;
    cyc(1'b1);
    cyc(1'b1);
    total_cnt++;
    if (duty !== 8'd200) $display("FAIL repeat_up_duty: got %0d, required 200", duty);
    else pass_cnt++;
    stop = 1'b1;
    cyc(1'b0);
    total_cnt++;
    if (duty !== 8'd0 || duty_upd !== 1'b1 || busy !== 1'b0 || cycle_done !== 1'b0)
      $display("FAIL stop_mid_up: duty=%0d upd=%0b busy=%0b done=%0b, required 0 1 0 0", duty, duty_upd, busy, cycle_done);
    else pass_cnt++;
    exp_prev = 0;
  endtask

  task automatic test_edge_configs;
    do_start(0, 3, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1);
      total_cnt++;
      if (duty !== 8'(k)) $display("FAIL step0_duty[%0d]: got %0d, required %0d", k, duty, k);
      else pass_cnt++;
    end
    stop = 1'b1;
    cyc(1'b0);
    exp_prev = 0;
    do_start(37, 0, 2, 0);
    build(37, 0, 2, 1);
    run_model(-1, 1'b1, 1);
    total_cnt++;
    if (upd_seen !== 0 || done_seen !== 1)
      $display("FAIL max0: upd pulses=%0d done pulses=%0d, required 0 and 1", upd_seen, done_seen);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    cfg_step = 8'd50; cfg_max = 8'd100; cfg_hold = 8'd1; repeat_en = 0;
    start = 1'b1; stop = 1'b1;
    cyc(1'b0);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL start_stop_busy: got %0b, required 0", busy);
    else pass_cnt++;
    start = 1'b1;
    cyc(1'b1);
    total_cnt++;
    if (busy !== 1'b1 || duty !== 8'd0) $display("FAIL start_tick: busy=%0b duty=%0d, required 1 and 0", busy, duty);
    else pass_cnt++;
    upd_seen = 0; done_seen = 0;
    build(50, 100, 1, 1);
    run_model(1, 1'b1, 0);
    cfg_step = 8'd7; cfg_max = 8'd9; cfg_hold = 8'd0;
    start = 1'b1;
    cyc(1'b0);
    total_cnt++;
    if (busy !== 1'b1 || duty !== 8'd50 || duty_upd !== 1'b0)
      $display("FAIL start_busy: busy=%0b duty=%0d upd=%0b, required 1 50 0", busy, duty, duty_upd);
    else pass_cnt++;
    run_model(-1, 1'b1, 1);
  endtask

  task automatic test_random;
    int s, m, h, nb;
    bit rep;
    for (int it = 0; it < 6; it++) begin
      s   = $urandom_range(0, 255);
      m   = $urandom_range(0, 255);
      h   = $urandom_range(0, 3);
      rep = 1'($urandom);
      nb  = rep ? 2 : 1;
      scramble = 1'b0;
      do_start(s, m, h, rep);
      scramble = 1'b1;
      build(s, m, h, nb);
      run_model(-1, !rep, 2);
      scramble = 1'b0;
      if (rep) begin
        stop = 1'b1;
        cyc(1'b0);
        total_cnt++;
        if (busy !== 1'b0 || duty !== 8'd0) $display("FAIL rand_stop: busy=%0b duty=%0d, required 0 0", busy, duty);
        else pass_cnt++;
      end
      exp_prev = 0;
    end
  endtask

  task automatic test_async_reset;
    do_start(128, 128, 5, 0);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    #3 rst = 1'b1;
    #1;
    total_cnt++;
    if (duty !== 8'd0 || busy !== 1'b0 || duty_upd !== 1'b0 || cycle_done !== 1'b0)
      $display("FAIL async_reset: duty=%0d busy=%0b upd=%0b done=%0b, required all 0", duty, busy, duty_upd, cycle_done);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_prev = 0;
    do_start(64, 255, 0, 0);
    build(64, 255, 0, 1);
    run_model(-1, 1'b1, 1);
  endtask

  initial begin
    test_reset;
    test_basic_ramp;
    test_hold_count;
    test_repeat_stop;
    test_edge_configs;
    test_simultaneous;
    test_random;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
